// File: rtl/chimera_clu_wake_seq_if.sv
// Host-side command/response handshake of the cluster wake/sleep sequencer.
// NumClusters must match the value given to the sequencer that uses it.
interface chimera_clu_wake_seq_if #(
  parameter int unsigned NumClusters = 5
) ();
  localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

  logic            req_valid;
  logic            req_ready;
  logic [IdxW-1:0] req_cluster;
  logic            req_sleep;
  logic            req_bypass;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_error;

  modport master (
    output req_valid, req_cluster, req_sleep, req_bypass, resp_ready,
    input  req_ready, resp_valid, resp_error
  );

  modport slave (
    input  req_valid, req_cluster, req_sleep, req_bypass, resp_ready,
    output req_ready, resp_valid, resp_error
  );
endinterface

// File: rtl/chimera_clu_wake_seq.sv
// Wake/sleep sequencer for the external Snitch clusters: gates cluster clocks,
// selects wide-memory bypass and pulses msip to every hart of a woken cluster.
module chimera_clu_wake_seq #(
  parameter int unsigned NumClusters     = 5,
  parameter int unsigned CoresPerCluster = 9,
  parameter int unsigned SettleCycles    = 16,
  parameter int unsigned IrqPulseCycles  = 4,
  parameter int unsigned IdleTimeout     = 1024
) (
  input  logic                                   i_soc_clk,
  input  logic                                   i_rst,
  chimera_clu_wake_seq_if.slave                  bus,
  input  logic [NumClusters-1:0]                 i_clu_idle,
  output logic [NumClusters-1:0]                 o_clu_clk_en,
  output logic [NumClusters-1:0]                 o_widemem_bypass,
  output logic [NumClusters*CoresPerCluster-1:0] o_msip,
  output logic                                   o_busy
);
  localparam int unsigned IdxW   = (NumClusters > 1) ? $clog2(NumClusters) : 1;
  localparam int unsigned MaxA   = (SettleCycles > IrqPulseCycles) ? SettleCycles : IrqPulseCycles;
  localparam int unsigned MaxCnt = (MaxA > IdleTimeout) ? MaxA : IdleTimeout;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
  localparam int unsigned MsipW  = NumClusters * CoresPerCluster;

  localparam logic [CntW-1:0] CntOne     = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] IrqLen     = CntW'(IrqPulseCycles);
  localparam logic [CntW-1:0] IdleLast   = CntW'(IdleTimeout - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_IRQ    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]             r_state;
  logic [CntW-1:0]        r_cnt;
  logic [IdxW-1:0]        r_cluster;
  logic [NumClusters-1:0] r_clk_en;
  logic [NumClusters-1:0] r_bypass;
  logic [MsipW-1:0]       r_msip;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic                   r_resp_error;
  logic                   r_busy;

  logic [NumClusters-1:0] w_req_hit;
  logic [NumClusters-1:0] w_cur_hit;
  logic [MsipW-1:0]       w_msip_mask;
  logic                   w_accept;
  logic                   w_req_in_range;
  logic                   w_req_clk_on;
  logic                   w_cur_idle;

  // One-hot decode of the incoming and latched cluster; out-of-range indices decode to zero.
  always_comb begin
    w_req_hit   = '0;
    w_cur_hit   = '0;
    w_msip_mask = '0;
    for (int c = 0; c < NumClusters; c++) begin
      w_req_hit[c] = (bus.req_cluster == IdxW'(c));
      w_cur_hit[c] = (r_cluster == IdxW'(c));
      w_msip_mask[c*CoresPerCluster +: CoresPerCluster] = {CoresPerCluster{w_cur_hit[c]}};
    end
  end

  assign w_accept       = bus.req_valid & r_req_ready;
  assign w_req_in_range = |w_req_hit;
  assign w_req_clk_on   = |(r_clk_en & w_req_hit);
  assign w_cur_idle     = |(i_clu_idle & w_cur_hit);

  // Sequencer state, phase counter and all registered outputs.
  always_ff @(posedge i_soc_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cluster    <= '0;
      r_clk_en     <= '0;
      r_bypass     <= '0;
      r_msip       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cluster   <= bus.req_cluster;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (!w_req_in_range) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
            end else if (!bus.req_sleep) begin
              // Clock and bypass are applied at the accept edge so settle starts immediately.
              r_clk_en <= r_clk_en | w_req_hit;
              r_bypass <= (r_bypass & ~w_req_hit) | (bus.req_bypass ? w_req_hit : '0);
              r_state  <= w_req_clk_on ? S_IRQ : S_SETTLE;
            end else if (!w_req_clk_on) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SettleLast) begin
            r_state <= S_IRQ;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        S_IRQ: begin
          if (r_cnt == IrqLen) begin
            r_msip       <= r_msip & ~w_msip_mask;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
          end else begin
            r_msip <= r_msip | w_msip_mask;
            r_cnt  <= r_cnt + CntOne;
          end
        end
        S_DRAIN: begin
          // Idle is tested first so it wins over a timeout on the same cycle.
          if (w_cur_idle) begin
            r_clk_en     <= r_clk_en & ~w_cur_hit;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
          end else if (r_cnt == IdleLast) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_msip       <= '0;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_error   = r_resp_error;
  assign o_clu_clk_en     = r_clk_en;
  assign o_widemem_bypass = r_bypass;
  assign o_msip           = r_msip;
  assign o_busy           = r_busy;
endmodule

// File: tb/tb_chimera_clu_wake_seq.sv
// Directed bench for chimera_clu_wake_seq with default parameters (5 clusters, 9 harts).
module tb_chimera_clu_wake_seq;
  localparam int unsigned NC = 5;
  localparam int unsigned CPC = 9;

  logic          clk;
  logic          rst;
  logic [NC-1:0] clu_idle;
  logic [NC-1:0] clk_en;
  logic [NC-1:0] bypass;
  logic [44:0]   msip;
  logic          busy;

  int n_pass;
  int n_total;

  chimera_clu_wake_seq_if #(.NumClusters(NC)) bus ();

  chimera_clu_wake_seq #(
    .NumClusters(NC), .CoresPerCluster(CPC), .SettleCycles(16),
    .IrqPulseCycles(4), .IdleTimeout(1024)
  ) dut (
    .i_soc_clk(clk), .i_rst(rst), .bus(bus), .i_clu_idle(clu_idle),
    .o_clu_clk_en(clk_en), .o_widemem_bypass(bypass), .o_msip(msip), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [44:0] mask_of(input int c);
    logic [44:0] m;
    m = 45'h1FF;
    return m << (CPC * c);
  endfunction

  task automatic send(input logic [2:0] c, input logic slp, input logic byp);
    check("ready_before_send", {63'd0, bus.req_ready}, 64'd1);
    bus.req_cluster = c;
    bus.req_sleep   = slp;
    bus.req_bypass  = byp;
    bus.req_valid   = 1'b1;
    tick();
    bus.req_valid   = 1'b0;
  endtask

  task automatic finish_resp(input logic exp_err);
    check("resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    check("resp_error", {63'd0, bus.resp_error}, {63'd0, exp_err});
    check("busy_in_resp", {63'd0, busy}, 64'd1);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("resp_cleared", {63'd0, bus.resp_valid}, 64'd0);
    check("ready_after_resp", {63'd0, bus.req_ready}, 64'd1);
    check("idle_not_busy", {63'd0, busy}, 64'd0);
  endtask

  // Waits settle_ticks with msip quiet, then checks a 4-cycle pulse on cluster c.
  task automatic irq_pulse(input int settle_ticks, input int c);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < settle_ticks; i++) begin
      tick();
      if (msip !== 45'd0) seen = 1'b1;
    end
    check("settle_msip_quiet", {63'd0, seen}, 64'd0);
    tick();
    check("msip_rise", {19'd0, msip}, {19'd0, mask_of(c)});
    repeat (3) tick();
    check("msip_hold", {19'd0, msip}, {19'd0, mask_of(c)});
    tick();
    check("msip_fall", {19'd0, msip}, 64'd0);
  endtask

  initial begin
    logic stable;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    clu_idle = '0;
    bus.req_valid = 1'b0;
    bus.req_cluster = 3'd0;
    bus.req_sleep = 1'b0;
    bus.req_bypass = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) tick();
    check("rst_clk_en", {59'd0, clk_en}, 64'd0);
    check("rst_msip", {19'd0, msip}, 64'd0);
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick();

    // Cold wake of cluster 2 with bypass.
    send(3'd2, 1'b0, 1'b1);
    check("wake_clk_en", {59'd0, clk_en}, 64'h04);
    check("wake_bypass", {59'd0, bypass}, 64'h04);
    check("wake_busy", {63'd0, busy}, 64'd1);
    check("wake_not_ready", {63'd0, bus.req_ready}, 64'd0);
    irq_pulse(16, 2);
    check("wake_clk_en_end", {59'd0, clk_en}, 64'h04);
    finish_resp(1'b0);

    // Warm wake: no settle, bypass cleared.
    send(3'd2, 1'b0, 1'b0);
    check("rewake_bypass", {59'd0, bypass}, 64'h00);
    irq_pulse(0, 2);
    finish_resp(1'b0);

    // Sleep with idle arriving 10 cycles after accept.
    send(3'd2, 1'b1, 1'b0);
    repeat (10) tick();
    check("drain_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    clu_idle = 5'b00100;
    check("drain_clk_still_on", {59'd0, clk_en}, 64'h04);
    tick();
    check("sleep_gated", {59'd0, clk_en}, 64'h00);
    clu_idle = '0;
    finish_resp(1'b0);

    // Re-wake, then sleep into a timeout.
    send(3'd2, 1'b0, 1'b1);
    irq_pulse(16, 2);
    finish_resp(1'b0);
    send(3'd2, 1'b1, 1'b0);
    repeat (1023) tick();
    check("timeout_not_yet", {63'd0, bus.resp_valid}, 64'd0);
    tick();
    check("timeout_clk_on", {59'd0, clk_en}, 64'h04);
    finish_resp(1'b1);

    // Idle on the very last drain cycle wins over the timeout.
    send(3'd2, 1'b1, 1'b0);
    repeat (1023) tick();
    check("last_cycle_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    clu_idle = 5'b00100;
    tick();
    check("last_cycle_gated", {59'd0, clk_en}, 64'h00);
    clu_idle = '0;
    finish_resp(1'b0);

    // Wake cluster 4 from cold; other bits untouched.
    send(3'd4, 1'b0, 1'b0);
    check("c4_clk_en", {59'd0, clk_en}, 64'h10);
    check("c4_bypass", {59'd0, bypass}, 64'h04);
    irq_pulse(16, 4);
    finish_resp(1'b0);

    // Out-of-range index, response held 20 cycles while a new request waits.
    send(3'd5, 1'b0, 1'b1);
    check("oor_clk_en", {59'd0, clk_en}, 64'h10);
    check("oor_bypass", {59'd0, bypass}, 64'h04);
    bus.req_cluster = 3'd0;
    bus.req_sleep = 1'b0;
    bus.req_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1 || bus.req_ready !== 1'b0 ||
          clk_en !== 5'b10000)
        stable = 1'b1 & 1'b0;
    end
    check("resp_hold_stable", {63'd0, stable}, 64'd1);
    bus.req_valid = 1'b0;
    finish_resp(1'b1);

    // Sleep of an already-gated cluster completes at once.
    send(3'd0, 1'b1, 1'b0);
    check("sleep_off_immediate", {63'd0, bus.resp_valid}, 64'd1);
    finish_resp(1'b0);

    // Reset in the middle of the msip pulse.
    send(3'd2, 1'b0, 1'b1);
    repeat (17) tick();
    check("pre_rst_msip", {19'd0, msip}, {19'd0, mask_of(2)});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_msip", {19'd0, msip}, 64'd0);
    check("mid_rst_clk_en", {59'd0, clk_en}, 64'd0);
    check("mid_rst_bypass", {59'd0, bypass}, 64'd0);
    check("mid_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    check("mid_rst_resp", {63'd0, bus.resp_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
